// File: rtl/nim_dac_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : nim_dac_scan_ctrl_if
// Description : DAC programming strobes and result-word stream shared by the
//               threshold-scan sequencer, DAC_Control and the burst FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface nim_dac_scan_ctrl_if;
  logic [15:0] dac_data;
  logic        dac_wr_blk;
  logic        dac_wr_dac;
  logic [63:0] res_data;
  logic        res_we;
  logic        res_ready;

  modport master (
    output dac_data, dac_wr_blk, dac_wr_dac, res_data, res_we,
    input  res_ready
  );

  modport slave (
    input  dac_data, dac_wr_blk, dac_wr_dac, res_data, res_we,
    output res_ready
  );
endinterface
`default_nettype wire

// File: rtl/nim_dac_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nim_dac_scan_ctrl
// Description : Threshold-scan sequencer for the NIM+ discriminators. Steps a
//               threshold over [thr_start..thr_stop], programs every enabled
//               channel's DAC, settles, clears and dwells on the input
//               counters, then streams one result word per channel plus a
//               trailer into the burst-write path.
// Revision    : 1.0 - initial release
// ============================================================================
module nim_dac_scan_ctrl #(
  parameter int CNT_W         = 32,
  parameter int SETTLE_CYCLES = 4096,
  parameter int CLR_CYCLES    = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [7:0]           chan_mask,
  input  logic [11:0]          thr_start,
  input  logic [11:0]          thr_stop,
  input  logic [11:0]          thr_step,
  input  logic [31:0]          dwell,
  input  logic [8*CNT_W-1:0]   counts_in,
  output logic                 reset_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  nim_dac_scan_ctrl_if.master  scan
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CHECK  = 4'd1,
    S_WR_BLK = 4'd2,
    S_WR_DAC = 4'd3,
    S_SETTLE = 4'd4,
    S_CLR    = 4'd5,
    S_DWELL  = 4'd6,
    S_LATCH  = 4'd7,
    S_EMIT   = 4'd8,
    S_NEXT   = 4'd9,
    S_END    = 4'd10
  } state_t;

  localparam logic [31:0] c_settle_ld = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] c_clr_ld    = 32'(CLR_CYCLES - 1);

  state_t             r_state;
  state_t             w_state_next;

  // Shadowed configuration: the scan never looks at the live config inputs.
  logic [7:0]         r_mask;
  logic [11:0]        r_thr_start;
  logic [11:0]        r_thr_stop;
  logic [11:0]        r_thr_step;
  logic [31:0]        r_dwell;

  logic [11:0]        r_thr;
  logic [2:0]         r_ch;
  logic [31:0]        r_tmr;
  logic [11:0]        r_npts;
  logic [CNT_W-1:0]   r_cnt [8];
  logic [15:0]        r_dac_last;
  logic               r_error;
  logic               r_done;

  logic [2:0]         w_first_ch;
  logic [2:0]         w_next_ch;
  logic               w_has_next;
  logic [12:0]        w_nxt;
  logic               w_past_stop;
  logic               w_cfg_bad;
  logic               w_tmr_zero;
  logic [15:0]        w_dac_live;
  logic [CNT_W-1:0]   w_cnt_sel;
  logic [31:0]        w_cnt32;

  assign w_nxt       = {1'b0, r_thr} + {1'b0, r_thr_step};
  assign w_past_stop = (w_nxt > {1'b0, r_thr_stop});
  assign w_cfg_bad   = (r_mask == 8'h00) || (r_thr_step == 12'h000) ||
                       (r_thr_start > r_thr_stop);
  assign w_tmr_zero  = (r_tmr == 32'h0);
  assign w_dac_live  = {1'b0, r_ch, r_thr};
  assign w_cnt_sel   = r_cnt[r_ch];
  assign error       = r_error;
  assign done        = r_done;

  // Result words carry exactly 32 count bits: truncate wide counters,
  // zero-extend narrow ones.
  generate
    if (CNT_W >= 32) begin : g_cnt_trunc
      assign w_cnt32 = w_cnt_sel[31:0];
    end else begin : g_cnt_ext
      assign w_cnt32 = {{(32 - CNT_W){1'b0}}, w_cnt_sel};
    end
  endgenerate

  // Lowest enabled channel, and the next enabled channel above r_ch.
  always_comb begin
    w_first_ch = 3'd0;
    w_next_ch  = 3'd0;
    w_has_next = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (r_mask[i]) begin
        w_first_ch = 3'(i);
        if (i > int'(r_ch)) begin
          w_next_ch  = 3'(i);
          w_has_next = 1'b1;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state decode and Moore outputs; abort overrides every state.
  always_comb begin
    w_state_next    = r_state;
    busy            = (r_state != S_IDLE);
    reset_cnt       = (r_state == S_CLR);
    scan.dac_wr_blk = (r_state == S_WR_BLK);
    scan.dac_wr_dac = (r_state == S_WR_DAC);
    scan.dac_data   = r_dac_last;
    scan.res_we     = (r_state == S_EMIT) || (r_state == S_END);
    scan.res_data   = 64'h0;
    if ((r_state == S_WR_BLK) || (r_state == S_WR_DAC)) scan.dac_data = w_dac_live;
    if (r_state == S_EMIT) scan.res_data = {4'hD, r_ch, 1'b0, r_thr, 12'h000, w_cnt32};
    if (r_state == S_END)  scan.res_data = {4'hE, 28'h0, 20'h0, r_npts};
    if (abort) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (start) w_state_next = S_CHECK;
        S_CHECK:  w_state_next = w_cfg_bad ? S_IDLE : S_WR_BLK;
        S_WR_BLK: w_state_next = S_WR_DAC;
        S_WR_DAC: w_state_next = w_has_next ? S_WR_BLK : S_SETTLE;
        S_SETTLE: if (w_tmr_zero) w_state_next = S_CLR;
        S_CLR:    if (w_tmr_zero) w_state_next = S_DWELL;
        S_DWELL:  if (w_tmr_zero) w_state_next = S_LATCH;
        S_LATCH:  w_state_next = S_EMIT;
        S_EMIT:   if (scan.res_ready) w_state_next = w_has_next ? S_EMIT : S_NEXT;
        S_NEXT:   w_state_next = w_past_stop ? S_END : S_WR_BLK;
        S_END:    if (scan.res_ready) w_state_next = S_IDLE;
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  // Datapath: shadow config, threshold/channel walk, phase timer, samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask      <= 8'h00;
      r_thr_start <= 12'h000;
      r_thr_stop  <= 12'h000;
      r_thr_step  <= 12'h000;
      r_dwell     <= 32'h0;
      r_thr       <= 12'h000;
      r_ch        <= 3'd0;
      r_tmr       <= 32'h0;
      r_npts      <= 12'h000;
      r_dac_last  <= 16'h0000;
      r_error     <= 1'b0;
      r_done      <= 1'b0;
      for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
    end else begin
      r_done <= (r_state == S_END) && scan.res_ready && !abort;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_mask      <= chan_mask;
            r_thr_start <= thr_start;
            r_thr_stop  <= thr_stop;
            r_thr_step  <= thr_step;
            r_dwell     <= dwell;
            r_error     <= 1'b0;
          end
        end
        S_CHECK: begin
          if (w_cfg_bad) begin
            if (!abort) r_error <= 1'b1;
          end else begin
            r_thr  <= r_thr_start;
            r_ch   <= w_first_ch;
            r_npts <= 12'h000;
          end
        end
        S_WR_BLK: r_dac_last <= w_dac_live;
        S_WR_DAC: begin
          if (w_has_next) r_ch  <= w_next_ch;
          else            r_tmr <= c_settle_ld;
        end
        S_SETTLE: r_tmr <= w_tmr_zero ? c_clr_ld : r_tmr - 32'd1;
        S_CLR: begin
          if (w_tmr_zero) r_tmr <= (r_dwell == 32'h0) ? 32'h0 : r_dwell - 32'd1;
          else            r_tmr <= r_tmr - 32'd1;
        end
        S_DWELL: if (!w_tmr_zero) r_tmr <= r_tmr - 32'd1;
        S_LATCH: begin
          for (int i = 0; i < 8; i++) r_cnt[i] <= counts_in[i*CNT_W +: CNT_W];
          r_ch <= w_first_ch;
        end
        S_EMIT: if (scan.res_ready && w_has_next) r_ch <= w_next_ch;
        S_NEXT: begin
          r_npts <= r_npts + 12'd1;
          if (!w_past_stop) begin
            r_thr <= w_nxt[11:0];
            r_ch  <= w_first_ch;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
